// File: rtl/fpu_result_collector.sv
// Captures fpu results over the rdy/ack handshake into a small FIFO, tagging each with its
// IEEE-754 class for writeback. Define FPU_RESULT_STATS_EN to add capture/NaN statistics counters.
module fpu_result_collector #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MANT_WIDTH = 23,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         fpu_result,
    input  logic                     fpu_output_rdy,
    output logic                     fpu_output_ack,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [WIDTH-1:0]         wb_data,
    output logic [4:0]               wb_class,
    output logic [$clog2(DEPTH):0]   count,
`ifdef FPU_RESULT_STATS_EN
    output logic [15:0]              stat_total,
    output logic [15:0]              stat_nan,
`endif
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 ack_q, ack_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 valid_q, valid_d;
    logic                 push;
    logic                 pop;
    logic [4:0]           class_c;

    logic [WIDTH-1:0]     data_q  [DEPTH];
    logic [4:0]           class_q [DEPTH];

    // {sign, nan, inf, zero, denorm}; the four magnitude classes are mutually exclusive
    function automatic logic [4:0] classify(input logic [WIDTH-1:0] r);
        logic [EXP_WIDTH-1:0]  e;
        logic [MANT_WIDTH-1:0] m;
        e = r[WIDTH-2:MANT_WIDTH];
        m = r[MANT_WIDTH-1:0];
        return {r[WIDTH-1], (&e) & (|m), (&e) & ~(|m), ~(|e) & ~(|m), ~(|e) & (|m)};
    endfunction

    assign class_c = classify(fpu_result);
    assign pop     = valid_q & wb_ready;

    // Capture FSM: one write per rdy assertion, gated by the registered full flag
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fpu_output_rdy && !full_q) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (fpu_output_rdy) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
        end
    end

    // Storage carries no reset; contents are don't-care while the entry is not valid
    always_ff @(posedge clock) begin
        if (push) begin
            data_q[wr_ptr_q]  <= fpu_result;
            class_q[wr_ptr_q] <= class_c;
        end
    end

`ifdef FPU_RESULT_STATS_EN
    logic [15:0] stat_total_q, stat_total_d;
    logic [15:0] stat_nan_q, stat_nan_d;

    // Saturating counters advance on the capture edge
    always_comb begin
        stat_total_d = stat_total_q;
        stat_nan_d   = stat_nan_q;
        if (push && (stat_total_q != 16'hFFFF)) begin
            stat_total_d = stat_total_q + 16'd1;
        end
        if (push && class_c[3] && (stat_nan_q != 16'hFFFF)) begin
            stat_nan_d = stat_nan_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_total_q <= '0;
            stat_nan_q   <= '0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_nan_q   <= stat_nan_d;
        end
    end

    assign stat_total = stat_total_q;
    assign stat_nan   = stat_nan_q;
`endif

    assign fpu_output_ack = ack_q;
    assign wb_valid       = valid_q;
    assign wb_data        = data_q[rd_ptr_q];
    assign wb_class       = class_q[rd_ptr_q];
    assign count          = count_q;
    assign full           = full_q;

endmodule

// File: doc/fpu_result_collector.md
Name: fpu_result_collector

Overview:
- Downstream stage of the fpu: consumes each result over the fpu's output_rdy/output_ack handshake and buffers it in a small FIFO.
- Classifies every captured result (NaN, infinity, zero, denormal, sign) and presents result plus class to register-file writeback over a valid/ready interface.
- Decouples fpu completion from writeback stalls; the fpu is never acknowledged until a FIFO slot exists.

Parameters:
- WIDTH, 32, result word width (IEEE-754 single).
- EXP_WIDTH, 8, exponent field width.
- MANT_WIDTH, 23, mantissa field width; WIDTH = 1 + EXP_WIDTH + MANT_WIDTH.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- fpu_result  in  WIDTH  fpu result word.
- fpu_output_rdy  in  1  fpu result valid; held until acknowledged.
- fpu_output_ack  out  1  capture acknowledge to fpu.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  writeback accepts head entry.
- wb_data  out  WIDTH  head entry result.
- wb_class  out  5  head class {sign, is_nan, is_inf, is_zero, is_denorm}.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (async, reset=0): FIFO emptied, pointers 0, count 0, full 0, wb_valid 0, fpu_output_ack 0, FSM to IDLE. Reset mid-handshake abandons the in-flight capture; wb_data/wb_class are don't-care while wb_valid=0.
- Capture FSM, states IDLE and ACK:
  - IDLE: if fpu_output_rdy=1 and full=0 at a rising edge, write fpu_result and its class into the tail, go to ACK, and fpu_output_ack goes to 1 (registered, visible the cycle after capture). If full=1, stay in IDLE with ack 0 and no write.
  - ACK: ack held at 1 while fpu_output_rdy=1; no further writes. When fpu_output_rdy=0, ack goes to 0 and the FSM returns to IDLE.
  - Exactly one entry is written per fpu_output_rdy assertion, however long rdy stays high.
- Classification, computed combinationally at write and stored with the entry; exp = result[WIDTH-2:MANT_WIDTH], mant = result[MANT_WIDTH-1:0]:
  - is_nan = exp all ones and mant != 0.
  - is_inf = exp all ones and mant == 0.
  - is_zero = exp == 0 and mant == 0.
  - is_denorm = exp == 0 and mant != 0.
  - sign = result[WIDTH-1].
  - At most one of nan/inf/zero/denorm is set.
- Read side: wb_valid = (count != 0). Head is popped on a rising edge with wb_valid and wb_ready both 1. wb_data/wb_class are driven from registered storage at the read pointer. wb_data and wb_class are stable while wb_valid=1 and wb_ready=0.
- Latency: a result captured at edge N appears on wb_valid after edge N when the FIFO was empty. There is no same-cycle pass-through.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push while full is impossible because capture is gated by registered full; a pop frees the slot for the next edge.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.

Optional Feature:
- Macro FPU_RESULT_STATS_EN.
- Defined: adds outputs stat_total [15:0] and stat_nan [15:0], counting captured results and captured NaN results respectively.
  - Both counters saturate at 16'hFFFF and clear on reset.
  - They increment on the capture edge.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single capture: fpu_result=32'h40800000 (4.0), rdy held 3 cycles, wb_ready=1 -> ack rises 1 cycle after capture and falls after rdy drops; one entry with wb_data=32'h40800000, wb_class=5'b00000; count returns 0.
- Class coverage: push 32'hFFFFFFFF, 32'hFF800000, 32'h80000000, 32'h00000001 with wb_ready=0 -> wb_class sequence 11000, 10100, 10010, 00001; then full=1 and count=4.
- Backpressure: FIFO full, fpu_output_rdy=1 -> ack stays 0, no write; pulse wb_ready for 1 cycle -> next edge captures, ack rises, count back to 4.
- Concurrent push/pop: count=2, capture and pop in the same edge -> count stays 2; FIFO order preserved across pointer wrap after 6 total pushes.
- Async reset mid-handshake: in ACK with count=3, drop reset between edges -> immediately ack=0, wb_valid=0, count=0; after release, a new rdy is captured normally.
- With FPU_RESULT_STATS_EN: push 3 results, one NaN (32'h7FC00000) -> stat_total=3, stat_nan=1; both read 0 after reset.
